poly_ram_pingpong: RTL and testbench
====================================

Name: poly_ram_pingpong

Overview:
- Parametrised successor to the single-bank polynomial coefficient RAM: two distributed-RAM banks of DEPTH x WIDTH used as ping-pong buffers between a producer stage (e.g. multiplier output) and a consumer stage (e.g. reduction/encode).
- Adds a hardware bank swap, a sequential clear engine that fills the write bank with CLEAR_VAL, out-of-range protection, and an optional registered read port.

Parameters:
- WIDTH, 13, coefficient width in bits (q = 5167 fits in 13 bits).
- DEPTH, 757, valid entries per bank (p).
- ADDR_W, 11, address width; DEPTH <= 2**ADDR_W is required.
- READ_REG, 0, read latency select: 0 = asynchronous read, 1 = registered read.
- CLEAR_VAL, 0, WIDTH-bit fill value written by the clear engine.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe to the current write bank.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  WIDTH  write data.
- wr_ready  out  1  high when user writes are accepted (IDLE state only).
- rd_addr  in  ADDR_W  read address into the current read bank.
- rd_data  out  WIDTH  read data.
- swap_req  in  1  one-cycle pulse requesting a bank exchange.
- swap_done  out  1  one-cycle pulse on the cycle after the swap takes effect.
- clear_start  in  1  one-cycle pulse: fill the write bank with CLEAR_VAL.
- clear_done  out  1  one-cycle pulse after the last clear write.
- wr_bank  out  1  index of the current write bank; the read bank is ~wr_bank.

Behaviour:
- Reset values: wr_bank=0, state=IDLE, clear counter=0, swap_pend=0, swap_done=0, clear_done=0, wr_ready=0 while rst is high and 1 in IDLE afterwards, rd_data=0 when READ_REG=1. RAM contents are not reset.
- States:
  - IDLE: user writes accepted.
  - CLEAR: counter runs 0..DEPTH-1 and writes CLEAR_VAL to wr_bank[counter], one entry per cycle. On counter==DEPTH-1 the FSM returns to IDLE and clear_done pulses the next cycle.
  - Clear duration is exactly DEPTH cycles. wr_ready=0 throughout, and user writes are dropped.
- Writes in IDLE: wr_en && wr_addr<DEPTH writes wr_bank[wr_addr] at the clock edge. wr_addr>=DEPTH is ignored with no aliasing.
- Reads:
  - READ_REG=0: rd_data = bank[~wr_bank][rd_addr] combinationally, or 0 when rd_addr>=DEPTH.
  - READ_REG=1: the same value is registered, giving 1-cycle latency; bank selection uses the pre-edge wr_bank.
  - Reads are unaffected by CLEAR, since only the write bank is cleared.
- Swap:
  - swap_req in IDLE toggles wr_bank at that edge; swap_done pulses the following cycle.
  - A write in the same cycle as swap_req lands in the old write bank, which becomes the read bank.
  - swap_req during CLEAR sets swap_pend. The swap executes on the edge where CLEAR ends, swap_done then pulses together with clear_done, and swap_pend clears.
  - Further swap_req pulses while swap_pend=1 are absorbed (no double toggle).
- Simultaneous swap_req and clear_start in IDLE: the swap executes at that edge, then CLEAR starts on the next cycle targeting the new write bank.
- clear_start during CLEAR is ignored; the counter does not restart.
- Read/write collision on the same bank cannot occur; banks are disjoint by construction.
- rst mid-CLEAR: FSM goes to IDLE, swap_pend=0, wr_bank=0. Partially cleared contents are left as-is.

Decomposition:
- Shared package poly_mem_pkg holds:
  - constants P=757, Q=5167, COEF_W=13, POLY_ADDR_W=11;
  - the state enum {IDLE, CLEAR}, reused by later multi-bank memories.
- Sub-module poly_ram_bank: a single distributed-RAM bank (WIDTH, ADDR_W) with a synchronous write and asynchronous read, instantiated twice. The FSM, swap logic, range checks and read mux/register live in the top module.

Test Plan:
- Reset, write addr 5=0x1ABC to bank 0, swap_req -> wr_bank=1, swap_done pulses 1 cycle later, read addr 5 returns 0x1ABC (READ_REG=0 same cycle; READ_REG=1 next cycle).
- Write 0x0FFF at addr 756 and addr 757 -> addr 756 holds 0x0FFF; read addr 757 returns 0; no other entry changes.
- clear_start in IDLE -> wr_ready=0 for exactly 757 cycles, clear_done pulses; swap and read all 757 entries -> all equal CLEAR_VAL; wr_en during clear leaves no trace.
- swap_req at clear cycle 100 -> wr_bank unchanged until clear end, then toggles; swap_done and clear_done pulse in the same cycle; a second swap_req at cycle 200 causes no extra toggle.
- swap_req, clear_start and wr_en(addr 3, 0x0123) in the same IDLE cycle -> 0x0123 readable at addr 3 from the new read bank; CLEAR runs on the new write bank starting next cycle.
- rst asserted at clear cycle 300 -> next cycle state=IDLE, wr_ready=1, wr_bank=0, no clear_done pulse, swap_pend cleared.

Source files
------------

// File: rtl/poly_mem_pkg.sv
// rtl/poly_mem_pkg.sv - shared constants and state type for polynomial coefficient memories
package poly_mem_pkg;

    localparam int P           = 757;
    localparam int Q           = 5167;
    localparam int COEF_W      = 13;
    localparam int POLY_ADDR_W = 11;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } mem_state_e;

endpackage

// File: rtl/poly_ram_bank.sv
// rtl/poly_ram_bank.sv - single distributed-RAM bank, synchronous write, asynchronous read
module poly_ram_bank #(
    parameter int WIDTH  = 13,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/poly_ram_pingpong.sv
// rtl/poly_ram_pingpong.sv - two-bank ping-pong coefficient RAM with swap and clear engine
module poly_ram_pingpong
    import poly_mem_pkg::*;
#(
    parameter int               WIDTH     = COEF_W,
    parameter int               DEPTH     = P,
    parameter int               ADDR_W    = POLY_ADDR_W,
    parameter int               READ_REG  = 0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              swap_req,
    output logic              swap_done,
    input  logic              clear_start,
    output logic              clear_done,
    output logic              wr_bank
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_bank_q, wr_bank_d;
    logic              swap_pend_q, swap_pend_d;
    logic              swap_done_q, swap_done_d;
    logic              clear_done_q, clear_done_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WIDTH-1:0]  mem_wdata;
    logic [WIDTH-1:0]  bank0_rdata, bank1_rdata;
    logic [WIDTH-1:0]  rd_mux;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_bank_d    = wr_bank_q;
        swap_pend_d  = swap_pend_q;
        swap_done_d  = 1'b0;
        clear_done_d = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = wr_addr;
        mem_wdata    = wr_data;
        case (state_q)
            IDLE: begin
                mem_we = wr_en && ({1'b0, wr_addr} < DEPTH_X);
                if (swap_req) begin
                    wr_bank_d   = ~wr_bank_q;
                    swap_done_d = 1'b1;
                end
                if (clear_start) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = cnt_q;
                mem_wdata = CLEAR_VAL;
                if (swap_req) begin
                    swap_pend_d = 1'b1;
                end
                if (cnt_q == LAST) begin
                    state_d      = IDLE;
                    cnt_d        = '0;
                    clear_done_d = 1'b1;
                    // A swap requested during the clear is applied as the clear retires.
                    if (swap_pend_q || swap_req) begin
                        wr_bank_d   = ~wr_bank_q;
                        swap_done_d = 1'b1;
                        swap_pend_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wr_bank_q    <= 1'b0;
            swap_pend_q  <= 1'b0;
            swap_done_q  <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_bank_q    <= wr_bank_d;
            swap_pend_q  <= swap_pend_d;
            swap_done_q  <= swap_done_d;
            clear_done_q <= clear_done_d;
        end
    end

    // Writes always target the bank selected before the edge, so a same-cycle swap
    // leaves the data in what becomes the read bank.
    poly_ram_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank0 (
        .clk   (clk),
        .we    (mem_we && !rst && !wr_bank_q),
        .waddr (mem_addr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (bank0_rdata)
    );

    poly_ram_bank #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_bank1 (
        .clk   (clk),
        .we    (mem_we && !rst && wr_bank_q),
        .waddr (mem_addr),
        .wdata (mem_wdata),
        .raddr (rd_addr),
        .rdata (bank1_rdata)
    );

    always_comb begin
        rd_mux = '0;
        if ({1'b0, rd_addr} < DEPTH_X) begin
            rd_mux = wr_bank_q ? bank0_rdata : bank1_rdata;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rd_reg
            logic [WIDTH-1:0] rd_data_q;
            logic [WIDTH-1:0] rd_data_d;
            assign rd_data_d = rd_mux;
            always_ff @(posedge clk) begin
                if (rst) begin
                    rd_data_q <= '0;
                end else begin
                    rd_data_q <= rd_data_d;
                end
            end
            assign rd_data = rd_data_q;
        end else begin : g_rd_comb
            assign rd_data = rd_mux;
        end
    endgenerate

    assign wr_ready   = (state_q == IDLE) && !rst;
    assign swap_done  = swap_done_q;
    assign clear_done = clear_done_q;
    assign wr_bank    = wr_bank_q;

endmodule

// File: tb/tb_poly_ram_pingpong.sv
// tb/tb_poly_ram_pingpong.sv - directed self-checking bench for poly_ram_pingpong
module tb_poly_ram_pingpong;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [12:0] wr_data;
    logic [10:0] rd_addr;
    logic        swap_req;
    logic        clear_start;

    logic        wr_ready, swap_done, clear_done, wr_bank;
    logic [12:0] rd_data;
    logic        r_wr_ready, r_swap_done, r_clear_done, r_wr_bank;
    logic [12:0] r_rd_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    poly_ram_pingpong u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_addr(rd_addr), .rd_data(rd_data), .swap_req(swap_req),
        .swap_done(swap_done), .clear_start(clear_start), .clear_done(clear_done),
        .wr_bank(wr_bank)
    );

    poly_ram_pingpong #(.READ_REG(1)) u_dut_r (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(r_wr_ready), .rd_addr(rd_addr), .rd_data(r_rd_data), .swap_req(swap_req),
        .swap_done(r_swap_done), .clear_start(clear_start), .clear_done(r_clear_done),
        .wr_bank(r_wr_bank)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [10:0] a, input logic [12:0] exp, input string tag);
        rd_addr = a;
        #1;
        check({tag, "_comb"}, 32'(rd_data), 32'(exp));
        tick();
        check({tag, "_reg"}, 32'(r_rd_data), 32'(exp));
    endtask

    task automatic do_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    // Runs one clear with wr_en hammering addr 10; optional swap pulses at given clear cycles.
    task automatic clear_run(input int swap_a, input int swap_b, output int n, output logic stable);
        logic start_bank;
        start_bank  = wr_bank;
        n           = 0;
        stable      = 1'b1;
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        while (wr_ready == 1'b0 && n < 2000) begin
            if (wr_bank !== start_bank) stable = 1'b0;
            swap_req = (n == swap_a) || (n == swap_b);
            wr_en    = 1'b1;
            wr_addr  = 11'd10;
            wr_data  = 13'h1555;
            tick();
            n++;
        end
        swap_req = 1'b0;
        wr_en    = 1'b0;
    endtask

    int   n;
    logic stable;
    logic seen;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr = '0; swap_req = 1'b0; clear_start = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_wr_bank", 32'(wr_bank), 32'd0);
        check("rst_wr_ready", 32'(wr_ready), 32'd0);
        check("rst_swap_done", 32'(swap_done), 32'd0);
        check("rst_clear_done", 32'(clear_done), 32'd0);
        check("rst_rd_reg", 32'(r_rd_data), 32'd0);
        rst = 1'b0;
        #1;
        check("idle_wr_ready", 32'(wr_ready), 32'd1);

        // Write then swap, read back from the new read bank
        wr_en = 1'b1; wr_addr = 11'd5; wr_data = 13'h1ABC;
        tick();
        wr_en = 1'b0;
        do_swap();
        rd_addr = 11'd5;
        #1;
        check("swap_wr_bank", 32'(wr_bank), 32'd1);
        check("swap_done_pulse", 32'(swap_done), 32'd1);
        check("rd5_comb", 32'(rd_data), 32'h1ABC);
        tick();
        check("swap_done_clr", 32'(swap_done), 32'd0);
        check("rd5_reg", 32'(r_rd_data), 32'h1ABC);

        // Clear bank 1, then make it the read bank and scan every entry
        clear_run(-1, -1, n, stable);
        check("clr1_cycles", 32'(n), 32'd757);
        check("clr1_done", 32'(clear_done), 32'd1);
        check("clr1_bank_stable", 32'(stable), 32'd1);
        tick();
        check("clr1_done_clr", 32'(clear_done), 32'd0);
        do_swap();
        check("clr1_swap_bank", 32'(wr_bank), 32'd0);
        for (int a = 0; a < 757; a++) begin
            read_check(11'(a), 13'h0, "scan");
        end

        // Range boundary on a freshly cleared bank 0
        clear_run(-1, -1, n, stable);
        check("clr0_cycles", 32'(n), 32'd757);
        wr_en = 1'b1; wr_addr = 11'd756; wr_data = 13'h0FFF;
        tick();
        wr_addr = 11'd757;
        tick();
        wr_en = 1'b0;
        do_swap();
        read_check(11'd756, 13'h0FFF, "rd756");
        read_check(11'd757, 13'h0, "rd757");
        read_check(11'd755, 13'h0, "rd755");
        read_check(11'd0, 13'h0, "rd0");
        read_check(11'd10, 13'h0, "rd10_no_trace");
        read_check(11'd2047, 13'h0, "rd2047");

        // Swap requests during clear are deferred and absorbed into one toggle
        check("pend_pre_bank", 32'(wr_bank), 32'd1);
        clear_run(100, 200, n, stable);
        check("pend_cycles", 32'(n), 32'd757);
        check("pend_bank_stable", 32'(stable), 32'd1);
        check("pend_bank_after", 32'(wr_bank), 32'd0);
        check("pend_swap_done", 32'(swap_done), 32'd1);
        check("pend_clear_done", 32'(clear_done), 32'd1);
        tick();
        check("pend_swap_done_clr", 32'(swap_done), 32'd0);
        check("pend_bank_hold", 32'(wr_bank), 32'd0);

        // Swap, clear and write all in one IDLE cycle
        swap_req = 1'b1; clear_start = 1'b1;
        wr_en = 1'b1; wr_addr = 11'd3; wr_data = 13'h0123;
        tick();
        swap_req = 1'b0; clear_start = 1'b0; wr_en = 1'b0;
        rd_addr = 11'd3;
        #1;
        check("combo_bank", 32'(wr_bank), 32'd1);
        check("combo_swap_done", 32'(swap_done), 32'd1);
        check("combo_in_clear", 32'(wr_ready), 32'd0);
        check("combo_rd3", 32'(rd_data), 32'h0123);
        n = 0;
        while (wr_ready == 1'b0 && n < 2000) begin
            tick();
            n++;
        end
        check("combo_clr_cycles", 32'(n), 32'd757);
        check("combo_clear_done", 32'(clear_done), 32'd1);
        read_check(11'd3, 13'h0123, "combo_rd3_after");

        // Reset in the middle of a clear with a swap pending
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        for (int c = 0; c < 300; c++) begin
            swap_req = (c == 50);
            tick();
        end
        swap_req = 1'b0;
        check("midrst_bank_before", 32'(wr_bank), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_wr_ready", 32'(wr_ready), 32'd1);
        check("midrst_bank", 32'(wr_bank), 32'd0);
        check("midrst_clear_done", 32'(clear_done), 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 500; c++) begin
            tick();
            if (clear_done || swap_done) seen = 1'b1;
        end
        check("midrst_no_pulse", 32'(seen), 32'd0);
        clear_run(-1, -1, n, stable);
        check("midrst_clr_cycles", 32'(n), 32'd757);
        check("midrst_pend_gone_bank", 32'(wr_bank), 32'd0);
        check("midrst_pend_gone_done", 32'(swap_done), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
